// File: rtl/vmem_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : vmem_rect_fill
// Description : Command-driven rectangle fill engine for the 24-bit video
//               memory. Accepts one fill command at a time while idle, clips
//               the lower-right corner to the visible screen, then issues one
//               memory write per cycle in raster order (x inner, y outer).
//               Writes pause while the memory port stalls; abort cancels.
// Ports       : clk, resetn       - clock, synchronous active-low reset
//               cmd_valid/ready   - command handshake (accepted only in IDLE)
//               cmd_x0/y0/x1/y1   - inclusive corners; cmd_color {R,G,B}
//               abort             - cancel current clip/fill, no done pulse
//               wr_stall          - memory port unavailable this cycle
//               wr_en/addr/data   - write port, addr = {x[9:0], y[8:0]}
//               busy              - engine in CLIP or FILL
//               done              - one-cycle pulse at end of every fill
// Revision    : 1.0 - initial release
// ============================================================================
module vmem_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [8:0]  cmd_y0,
    input  logic [9:0]  cmd_x1,
    input  logic [8:0]  cmd_y1,
    input  logic [23:0] cmd_color,
    input  logic        abort,
    input  logic        wr_stall,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CLIP = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [9:0] c_X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] c_Y_MAX = 9'(V_RES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [9:0]  r_x0;
    logic [8:0]  r_y0;
    logic [9:0]  r_x1;      // raw corner until CLIP, clipped corner afterwards
    logic [8:0]  r_y1;
    logic [9:0]  r_cur_x;
    logic [8:0]  r_cur_y;
    logic [23:0] r_color;

    logic [9:0]  w_x1c;
    logic [8:0]  w_y1c;
    logic        w_empty;
    logic        w_last_x;
    logic        w_last;
    logic        w_wr_en;

    assign w_x1c   = (r_x1 > c_X_MAX) ? c_X_MAX : r_x1;
    assign w_y1c   = (r_y1 > c_Y_MAX) ? c_Y_MAX : r_y1;
    // Covers inverted corners and a start corner that is entirely off-screen.
    assign w_empty = (r_x0 > w_x1c) || (r_y0 > w_y1c);

    // Only meaningful in FILL, where r_x1/r_y1 already hold the clipped corner.
    assign w_last_x = (r_cur_x == r_x1);
    assign w_last   = w_last_x && (r_cur_y == r_y1);

    assign wr_addr = {r_cur_x, r_cur_y};
    assign wr_data = r_color;
    assign wr_en   = w_wr_en;

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = c_CLIP;
                end
            end
            c_CLIP: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = c_IDLE;
                end else if (w_empty) begin
                    w_next = c_DONE;
                end else begin
                    w_next = c_FILL;
                end
            end
            c_FILL: begin
                busy = 1'b1;
                // Abort takes priority over everything, including a free port.
                w_wr_en = ~wr_stall & ~abort;
                if (abort) begin
                    w_next = c_IDLE;
                end else if (w_wr_en && w_last) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                done   = 1'b1;
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_x0    <= cmd_x0;
                        r_y0    <= cmd_y0;
                        r_x1    <= cmd_x1;
                        r_y1    <= cmd_y1;
                        r_color <= cmd_color;
                    end
                end
                c_CLIP: begin
                    r_x1    <= w_x1c;
                    r_y1    <= w_y1c;
                    r_cur_x <= r_x0;
                    r_cur_y <= r_y0;
                end
                c_FILL: begin
                    // Counters stop at the final pixel so the address never
                    // runs past the clipped corner.
                    if (w_wr_en && !w_last) begin
                        if (!w_last_x) begin
                            r_cur_x <= r_cur_x + 10'd1;
                        end else begin
                            r_cur_x <= r_x0;
                            r_cur_y <= r_cur_y + 9'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmem_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem_rect_fill
// Description : Self-checking bench for vmem_rect_fill. Expected writes are
//               generated from a reference clip/raster model into a queue when
//               a command is issued and compared as the DUT writes. The screen
//               height is reduced so the full-screen fill stays short while the
//               full 640-pixel line width is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmem_rect_fill;

    localparam int H = 640;
    localparam int V = 40;
    localparam int BUDGET = 40000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [8:0]  cmd_y0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [8:0]  cmd_y1 = '0;
    logic [23:0] cmd_color = '0;
    logic        abort = 1'b0;
    logic        wr_stall = 1'b0;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [42:0] exp_q[$];

    // Results of the most recent send_cmd call; cycle 1 is the cycle after acceptance.
    int          t_done_at;
    int          t_done_cnt;
    int          t_ready_at;
    int          t_writes;
    int          t_first_at;
    logic [18:0] t_stall_addr;
    logic [18:0] t_last_addr;

    vmem_rect_fill #(.H_RES(H), .V_RES(V)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .abort     (abort),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write is matched against the next expected pixel.
    always @(negedge clk) begin
        #2;
        if (busy && cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_ready_overlap busy=%0b cmd_ready=%0b required not both 1", busy, cmd_ready);
        end
        if (wr_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write addr=%h data=%h required no write", wr_addr, wr_data);
            end else begin
                logic [42:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL sb_write addr=%h data=%h required addr=%h data=%h",
                             wr_addr, wr_data, e[42:24], e[23:0]);
                end
            end
        end
    end

    task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                            input logic [9:0] x1, input logic [8:0] y1,
                            input logic [23:0] col, input int stall_a, input int stall_b,
                            input int abort_at, input int pulse_at);
        int xe;
        int ye;
        bit aborted;
        xe = (int'(x1) > H - 1) ? H - 1 : int'(x1);
        ye = (int'(y1) > V - 1) ? V - 1 : int'(y1);
        for (int y = int'(y0); y <= ye; y++) begin
            for (int x = int'(x0); x <= xe; x++) begin
                exp_q.push_back({10'(x), 9'(y), col});
            end
        end
        t_done_at = -1; t_done_cnt = 0; t_ready_at = -1; t_writes = 0; t_first_at = -1;
        t_stall_addr = '0; t_last_addr = '0; aborted = 1'b0;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = col;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            wr_stall = (cyc >= stall_a) && (cyc <= stall_b);
            abort    = (abort_at >= 0) && (t_writes == abort_at) && !aborted;
            if (cyc == pulse_at) begin
                cmd_valid = 1'b1;
                cmd_x0 = 10'd1; cmd_y0 = 9'd1; cmd_x1 = 10'd2; cmd_y1 = 9'd2;
                cmd_color = 24'h0F0F0F;
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (abort) aborted = 1'b1;
            if (wr_en) begin
                t_writes++;
                if (t_first_at < 0) t_first_at = cyc;
                t_last_addr = wr_addr;
            end
            if (wr_stall) t_stall_addr = wr_addr;
            if (done) begin
                t_done_at = cyc;
                t_done_cnt++;
            end
            if (cmd_ready) begin
                t_ready_at = cyc;
                break;
            end
            @(negedge clk);
        end
        wr_stall = 1'b0;
        abort = 1'b0;
        cmd_valid = 1'b0;
        n_tests++;
        if (t_ready_at < 0) begin
            n_fail++;
            $display("FAIL cmd_timeout cmd_ready not seen within %0d cycles", BUDGET);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got=%b required=1", cmd_ready); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b required=0", wr_en); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b required=0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b required=0", busy); end
        n_tests++; if (wr_addr !== 19'd0) begin n_fail++; $display("FAIL rst_wr_addr got=%h required=0", wr_addr); end
        n_tests++; if (wr_data !== 24'd0) begin n_fail++; $display("FAIL rst_wr_data got=%h required=0", wr_data); end
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_release cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_2x2();
        send_cmd(10'd0, 9'd0, 10'd1, 9'd1, 24'hFF0000, -1, -1, -1, -1);
        n_tests++; if (t_writes != 4) begin n_fail++; $display("FAIL b2x2_writes got=%0d required=4", t_writes); end
        n_tests++; if (t_first_at != 2) begin n_fail++; $display("FAIL b2x2_first got=%0d required=2", t_first_at); end
        n_tests++; if (t_done_at != 6 || t_done_cnt != 1) begin
            n_fail++; $display("FAIL b2x2_done at=%0d cnt=%0d required at=6 cnt=1", t_done_at, t_done_cnt);
        end
        n_tests++; if (t_ready_at != 7) begin n_fail++; $display("FAIL b2x2_ready got=%0d required=7", t_ready_at); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2x2_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_clip();
        send_cmd(10'd638, 9'(V - 2), 10'd1023, 9'd511, 24'h00FF00, -1, -1, -1, -1);
        n_tests++; if (t_writes != 4) begin n_fail++; $display("FAIL clip_writes got=%0d required=4", t_writes); end
        n_tests++; if (t_last_addr !== {10'd639, 9'(V - 1)}) begin
            n_fail++; $display("FAIL clip_last got=%h required=%h", t_last_addr, {10'd639, 9'(V - 1)});
        end
        n_tests++; if (t_done_at != 6) begin n_fail++; $display("FAIL clip_done got=%0d required=6", t_done_at); end
        send_cmd(10'd5, 9'd5, 10'd4, 9'd9, 24'h0000FF, -1, -1, -1, -1);
        n_tests++; if (t_writes != 0) begin n_fail++; $display("FAIL inv_writes got=%0d required=0", t_writes); end
        n_tests++; if (t_done_at != 2 || t_done_cnt != 1) begin
            n_fail++; $display("FAIL inv_done at=%0d cnt=%0d required at=2 cnt=1", t_done_at, t_done_cnt);
        end
        n_tests++; if (t_ready_at != 3) begin n_fail++; $display("FAIL inv_ready got=%0d required=3", t_ready_at); end
        send_cmd(10'd700, 9'd3, 10'd710, 9'd4, 24'h00FFFF, -1, -1, -1, -1);
        n_tests++; if (t_writes != 0 || t_done_at != 2) begin
            n_fail++; $display("FAIL offscreen writes=%0d done=%0d required 0/2", t_writes, t_done_at);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        send_cmd(10'd10, 9'd20, 10'd12, 9'd20, 24'hABCDEF, 3, 4, -1, -1);
        n_tests++; if (t_writes != 3) begin n_fail++; $display("FAIL stall_writes got=%0d required=3", t_writes); end
        n_tests++; if (t_stall_addr !== {10'd11, 9'd20}) begin
            n_fail++; $display("FAIL stall_addr got=%h required=%h", t_stall_addr, {10'd11, 9'd20});
        end
        n_tests++; if (t_done_at != 7) begin n_fail++; $display("FAIL stall_done got=%0d required=7", t_done_at); end
        n_tests++; if (t_ready_at != 8) begin n_fail++; $display("FAIL stall_ready got=%0d required=8", t_ready_at); end
    endtask

    task automatic test_abort();
        send_cmd(10'd0, 9'd0, 10'd639, 9'(V - 1), 24'h112233, -1, -1, 100, -1);
        exp_q.delete();
        n_tests++; if (t_writes != 100) begin n_fail++; $display("FAIL abort_writes got=%0d required=100", t_writes); end
        n_tests++; if (t_done_cnt != 0) begin n_fail++; $display("FAIL abort_done got=%0d pulses required=0", t_done_cnt); end
        n_tests++; if (t_ready_at != 103) begin n_fail++; $display("FAIL abort_idle got=%0d required=103", t_ready_at); end
        send_cmd(10'd7, 9'd9, 10'd7, 9'd9, 24'h445566, -1, -1, -1, -1);
        n_tests++; if (t_writes != 1 || t_done_at != 3) begin
            n_fail++; $display("FAIL post_abort writes=%0d done=%0d required 1/3", t_writes, t_done_at);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL post_abort_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_full_screen();
        send_cmd(10'd0, 9'd0, 10'd639, 9'(V - 1), 24'h808080, -1, -1, -1, 50);
        n_tests++; if (t_writes != H * V) begin n_fail++; $display("FAIL full_writes got=%0d required=%0d", t_writes, H * V); end
        n_tests++; if (t_last_addr !== {10'd639, 9'(V - 1)}) begin
            n_fail++; $display("FAIL full_last got=%h required=%h", t_last_addr, {10'd639, 9'(V - 1)});
        end
        n_tests++; if (t_done_at != H * V + 2) begin n_fail++; $display("FAIL full_done got=%0d required=%0d", t_done_at, H * V + 2); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        send_cmd(10'd100, 9'd10, 10'd102, 9'd11, 24'hC0FFEE, -1, -1, -1, -1);
        n_tests++; if (t_ready_at != 9) begin n_fail++; $display("FAIL b2b_first got=%0d required=9", t_ready_at); end
        send_cmd(10'd3, 9'd3, 10'd3, 9'd3, 24'hBEEF00, -1, -1, -1, -1);
        n_tests++; if (t_ready_at != 4 || t_writes != 1) begin
            n_fail++; $display("FAIL b2b_second ready=%0d writes=%0d required 4/1", t_ready_at, t_writes);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing got=%0d pending required=0", exp_q.size()); end
    endtask

    task automatic test_reset_midfill();
        for (int x = 0; x < 10; x++) exp_q.push_back({10'(x), 9'd0, 24'h777777});
        cmd_x0 = 10'd0; cmd_y0 = 9'd0; cmd_x1 = 10'd9; cmd_y1 = 9'd0; cmd_color = 24'h777777;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en got=%b required=0", wr_en); end
        n_tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
        n_tests++; if (wr_addr !== 19'd0 || wr_data !== 24'd0) begin
            n_fail++; $display("FAIL midrst_regs addr=%h data=%h required 0/0", wr_addr, wr_data);
        end
        resetn = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_2x2();
        test_clip();
        test_stall();
        test_abort();
        test_back_to_back();
        test_full_screen();
        test_reset_midfill();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vmem_rect_fill.md
# vmem_rect_fill

Command-driven rectangle fill engine for the 640x480, 24-bit video memory behind the VGA scan-out path. It accepts one fill command at a time (corner coordinates plus colour), clips it to the visible screen, and streams one memory write per cycle in raster order. Writes pause whenever the downstream memory port signals a stall, for example while scan-out owns the port. It sits between the keyboard/console logic (or a future CPU bus) and the vmem write port, and is the only writer of vmem.

## Interface
Parameters:
- H_RES, 640: visible pixels per line; x coordinates at or above H_RES are off-screen.
- V_RES, 480: visible lines; y coordinates at or above V_RES are off-screen.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present on cmd_* inputs.
- cmd_ready  output  1  engine idle and able to accept a command.
- cmd_x0  input  10  left column, inclusive.
- cmd_y0  input  9  top line, inclusive.
- cmd_x1  input  10  right column, inclusive.
- cmd_y1  input  9  bottom line, inclusive.
- cmd_color  input  24  fill colour {R[7:0],G[7:0],B[7:0]}.
- abort  input  1  cancel the fill in progress.
- wr_stall  input  1  memory port unavailable this cycle.
- wr_en  output  1  write strobe; the write occurs in every cycle this is high.
- wr_addr  output  19  {x[9:0], y[8:0]}, same packing as the vmem read address.
- wr_data  output  24  colour to write.
- busy  output  1  engine is in CLIP or FILL.
- done  output  1  one-cycle pulse when a fill completes, including an empty fill.

## Operation
- States: IDLE, CLIP, FILL, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch x0, y0, x1, y1 and colour, then go to CLIP. No other state accepts commands, and cmd_* inputs are ignored outside IDLE.
- CLIP:
  - x1c = min(x1, H_RES-1) and y1c = min(y1, V_RES-1).
  - The rectangle is empty if x0>x1c or y0>y1c. This covers inverted corners and x0>=H_RES or y0>=V_RES.
  - Empty goes to DONE with no writes. Otherwise load cur_x=x0, cur_y=y0 and go to FILL.
- FILL:
  - wr_en = ~wr_stall (combinational from the registered state). wr_addr={cur_x,cur_y}. wr_data = the latched colour.
  - When wr_en=1, advance: if cur_x<x1c then cur_x+1; else cur_x=x0 and cur_y+1.
  - The write at (x1c,y1c) goes to DONE.
  - With wr_stall=1: wr_en=0, and cur_x/cur_y hold.
- DONE: done=1 for exactly one cycle, then IDLE.
- Raster order: x inner loop, y outer loop. The pixel count is (x1c-x0+1)*(y1c-y0+1), at most 307200. Counters never exceed x1c/y1c, so the address never wraps.
- Abort:
  - Sampled in CLIP and FILL. It goes to IDLE the next cycle with no done pulse.
  - wr_en is forced to 0 in any cycle where abort=1.
  - Abort in IDLE or DONE has no effect; a DONE pulse is not suppressed.
- Simultaneous wr_stall and abort: abort wins, no write.

## Timing
- Reset (resetn=0 at an edge): state=IDLE. cmd_ready=1; wr_en=0, busy=0, done=0. wr_addr=0, wr_data=0, and the latched registers are cleared. A reset mid-fill stops writes in the following cycle.
- Accept at edge T. CLIP during T+1. The first write is in cycle T+2.
- With no stalls, N pixels are written in cycles T+2..T+1+N. done is high in T+2+N, and cmd_ready returns in T+3+N.
- An empty command gives done in T+2 and cmd_ready in T+3.
- Each stall cycle adds exactly one cycle to the latency.
- busy = state∈{CLIP,FILL}. cmd_ready = state==IDLE. The two are never both 1.
- Back-to-back throughput: N+3 cycles per command.

## Test plan
- Reset: hold resetn=0 for 3 cycles, then release. Required: cmd_ready=1, wr_en=0, done=0, busy=0.
- 2x2 fill at (0,0)-(1,1), colour 0xFF0000, no stall. Required writes in order: addr {0,0}, {1,0}, {0,1}, {1,1}, i.e. 0x00000, 0x00200, 0x00001, 0x00201, all with data 0xFF0000, in cycles T+2..T+5. done in T+6.
- Clipping: command (638,478)-(1023,511). Required: exactly 4 writes, to x∈{638,639}, y∈{478,479}. Inverted command (5,5)-(4,9): zero writes, done at T+2.
- Stall: 1x3 fill (10,20)-(12,20) with wr_stall high in cycles T+3 and T+4. Required: wr_en low in those cycles, addr held at {11,20}, three writes total, done at T+7.
- Abort: full-screen fill, abort raised after 100 writes. Required: no further wr_en, no done pulse, IDLE next cycle. A following 1x1 command executes normally.
- Full screen (0,0)-(639,479): required 307200 writes, the last at {639,479}. Also check a cmd_valid pulse while busy is ignored.
